lif_config_sequencer: RTL and testbench
=======================================

# lif_config_sequencer

Configuration controller that sits in front of the LIF neuron system's serial configuration port (`load_mode`/`serial_data`). It accepts a parallel parameter bundle over a valid/ready handshake and checks it. It then serializes the bundle into a fixed 24-bit frame, waits for the system's `params_ready` confirmation, and reports done, timeout or abort. While a load is in flight it asserts `neuron_hold` so upstream logic can gate `chan_a`/`chan_b` to zero.

## Interface
- `TIMEOUT_CYC`, default 64: maximum enabled cycles spent in WAIT before a timeout error; legal range 1..255.
- `clk` in 1: system clock; all logic rises on posedge.
- `reset` in 1: synchronous, active-high.
- `enable` in 1: global enable; when low, all state, counters and outputs hold.
- `cfg_valid` in 1: parameter bundle valid.
- `cfg_ready` out 1: sequencer can accept a bundle (IDLE only).
- `cfg_weight_a`, `cfg_weight_b` in 3 each: synaptic weights.
- `cfg_leak` in 2: leak configuration.
- `cfg_tmin`, `cfg_tmax` in 8 each: threshold window.
- `cfg_abort` in 1: cancel an in-flight load.
- `params_ready` in 1: confirmation from the neuron system.
- `load_mode` out 1: drives the system's `load_mode`.
- `serial_data` out 1: drives the system's `serial_data`.
- `neuron_hold` out 1: high while a load is in flight.
- `cfg_done` out 1: one-cycle pulse on successful load.
- `cfg_err` out 1: one-cycle pulse on any error.
- `err_code` out 2: last result. 0 = OK, 1 = RANGE, 2 = TIMEOUT, 3 = ABORT. Held until the next accept or error.
- `load_count` out 8: successful loads, saturating at 255.

## Operation
- Frame is 24 bits, MSB first, in this order: `weight_a`[2:0], `weight_b`[2:0], `leak`[1:0], `tmin`[7:0], `tmax`[7:0]. Frame bit 23 = `weight_a`[2].
- **IDLE**
  - `cfg_ready`=1, `load_mode`=0, `neuron_hold`=0.
  - Accept occurs on `cfg_valid & cfg_ready & enable`.
  - If `cfg_tmin > cfg_tmax` (unsigned): pulse `cfg_err`, set `err_code`=RANGE, stay IDLE; nothing is shifted.
  - Otherwise: latch the frame into the shift register, clear the bit counter, set `err_code`=0, go to SHIFT.
- **SHIFT**
  - `load_mode`=1, `serial_data`=shreg[23], `neuron_hold`=1.
  - Each enabled cycle, shift left by 1 and increment the counter.
  - After the 24th bit, go to WAIT with the timer and `seen_low` cleared.
- **WAIT**
  - `load_mode`=0, `serial_data`=0, `neuron_hold`=1.
  - Set `seen_low` when `params_ready`=0 is sampled during SHIFT or WAIT.
  - Success when `seen_low` is set and `params_ready`=1: pulse `cfg_done`, increment `load_count` (saturating), go to IDLE.
  - Otherwise the timer increments. When it reaches `TIMEOUT_CYC`: pulse `cfg_err`, set `err_code`=TIMEOUT, go to IDLE.
- `cfg_abort` in SHIFT or WAIT:
  - Takes priority over success and timeout in the same cycle.
  - Go to IDLE with `load_mode`=0, pulse `cfg_err`, set `err_code`=ABORT.
  - Ignored in IDLE.
- Reset mid-operation: return to IDLE; all outputs take their reset values on the next edge and no partial frame continues.

## Timing
- Reset values: state IDLE, `cfg_ready`=1. All other outputs are 0: `load_mode`, `serial_data`, `neuron_hold`, `cfg_done`, `cfg_err`, `err_code`, `load_count`.
- All outputs are registered.
- Accept at edge N: `load_mode`=1 and `serial_data`=frame[23] from cycle N+1.
- `load_mode` stays high for exactly 24 enabled cycles; frame[23-k] is presented in the k-th cycle.
- `enable` low stretches a bit period without corrupting the frame.
- First WAIT cycle is N+25 when enable is continuously high.
- `cfg_done`/`cfg_err` assert in the cycle after the deciding sample, simultaneous with `cfg_ready` returning high.
- Back-to-back accept is allowed in the cycle `cfg_done` is high.
- RANGE error: `cfg_err` is high in cycle N+1 and `cfg_ready` never drops.
- Timeout: `cfg_err` rises exactly `TIMEOUT_CYC` enabled cycles after WAIT entry.

## Structure
- Package `lif_cfg_pkg` holds:
  - state enum (IDLE, SHIFT, WAIT);
  - `err_code` constants;
  - `FRAME_W`=24 and the field bit offsets, also used by the system's data loader and its testbench models.
- One sub-module, `lif_cfg_serializer`: 24-bit load/shift register plus bit counter, with load, shift-enable and `last_bit` ports.
- The FSM, timer, `seen_low`, status and counter logic stay in the top.

## Test plan
- Nominal load: bundle wa=5, wb=2, leak=1, tmin=0x20, tmax=0x80 → `serial_data` sequence 101_010_01_00100000_10000000 under 24 cycles of `load_mode`; model drops then raises `params_ready` → `cfg_done` pulse, `load_count`=1, `err_code`=0.
- Range reject: tmin=0x90, tmax=0x10 → `cfg_err` at N+1, `err_code`=1, `load_mode` never rises, `cfg_ready` stays 1.
- Timeout with `TIMEOUT_CYC`=8: `params_ready` held low → `cfg_err` 8 enabled cycles after WAIT entry, `err_code`=2. Stale high: `params_ready` stuck high throughout → also times out (`seen_low` never set).
- Abort: `cfg_abort` at bit 10 of SHIFT → `load_mode`=0 on the next cycle, `err_code`=3, `neuron_hold`=0, `load_count` unchanged; repeat with abort coinciding with the success sample → abort wins.
- Enable gaps and reset: toggle `enable` low for 3 cycles at bits 5 and 20 → frame is bit-exact and 24 `load_mode`-enabled cycles are counted; assert `reset` mid-SHIFT → next cycle all outputs at reset values.
- Saturation: 256 successful loads → `load_count` stays at 255.

Source files
------------

// File: rtl/lif_cfg_pkg.sv
// Shared definitions for the LIF configuration path: frame layout, FSM states
// and result codes, also used by the data loader and its models.
package lif_cfg_pkg;

    localparam int FRAME_W  = 24;
    localparam int CNT_W    = $clog2(FRAME_W);

    localparam int WA_LSB   = 21;
    localparam int WB_LSB   = 18;
    localparam int LEAK_LSB = 16;
    localparam int TMIN_LSB = 8;
    localparam int TMAX_LSB = 0;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        WAIT
    } state_e;

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_RANGE   = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_ABORT   = 2'd3;

    function automatic logic [FRAME_W-1:0] pack_frame(
        input logic [2:0] weight_a,
        input logic [2:0] weight_b,
        input logic [1:0] leak,
        input logic [7:0] tmin,
        input logic [7:0] tmax
    );
        logic [FRAME_W-1:0] frame;
        frame                 = '0;
        frame[WA_LSB   +: 3]  = weight_a;
        frame[WB_LSB   +: 3]  = weight_b;
        frame[LEAK_LSB +: 2]  = leak;
        frame[TMIN_LSB +: 8]  = tmin;
        frame[TMAX_LSB +: 8]  = tmax;
        return frame;
    endfunction

endpackage

// File: rtl/lif_cfg_serializer.sv
// MSB-first frame shift register with bit counter; zero-fills so the line
// idles low once the whole frame has been shifted out.
module lif_cfg_serializer
    import lif_cfg_pkg::*;
(
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               clr_i,
    input  logic               load_i,
    input  logic               shift_i,
    input  logic [FRAME_W-1:0] frame_i,
    output logic               msb_o,
    output logic               last_bit_o
);

    logic [FRAME_W-1:0] shreg_q;
    logic [CNT_W-1:0]   cnt_q;

    // NOTE: sequential state is updated with <= so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (reset_i || clr_i) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else if (load_i) begin
            shreg_q <= frame_i;
            cnt_q   <= '0;
        end else if (shift_i) begin
            shreg_q <= {shreg_q[FRAME_W-2:0], 1'b0};
            cnt_q   <= cnt_q + CNT_W'(1);
        end
    end

    assign msb_o      = shreg_q[FRAME_W-1];
    assign last_bit_o = (cnt_q == CNT_W'(FRAME_W - 1));

endmodule

// File: rtl/lif_config_sequencer.sv
// Accepts a parameter bundle, range-checks it, shifts it to the neuron system
// and waits for a low-then-high params_ready confirmation.
module lif_config_sequencer
    import lif_cfg_pkg::*;
#(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       enable_i,
    input  logic       cfg_valid_i,
    output logic       cfg_ready_o,
    input  logic [2:0] cfg_weight_a_i,
    input  logic [2:0] cfg_weight_b_i,
    input  logic [1:0] cfg_leak_i,
    input  logic [7:0] cfg_tmin_i,
    input  logic [7:0] cfg_tmax_i,
    input  logic       cfg_abort_i,
    input  logic       params_ready_i,
    output logic       load_mode_o,
    output logic       serial_data_o,
    output logic       neuron_hold_o,
    output logic       cfg_done_o,
    output logic       cfg_err_o,
    output logic [1:0] err_code_o,
    output logic [7:0] load_count_o
);

    state_e     state_q, state_d;
    logic [7:0] timer_q, timer_d;
    logic       seen_low_q, seen_low_d;
    logic       cfg_ready_q, cfg_ready_d;
    logic       load_mode_q, load_mode_d;
    logic       neuron_hold_q, neuron_hold_d;
    logic       cfg_done_q, cfg_done_d;
    logic       cfg_err_q, cfg_err_d;
    logic [1:0] err_code_q, err_code_d;
    logic [7:0] load_count_q, load_count_d;

    logic ser_load, ser_shift, ser_clr, ser_msb, ser_last;

    lif_cfg_serializer u_serializer (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .clr_i      (ser_clr),
        .load_i     (ser_load),
        .shift_i    (ser_shift),
        .frame_i    (pack_frame(cfg_weight_a_i, cfg_weight_b_i, cfg_leak_i,
                                cfg_tmin_i, cfg_tmax_i)),
        .msb_o      (ser_msb),
        .last_bit_o (ser_last)
    );

    // NOTE: every variable gets a default before any branch, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        seen_low_d    = seen_low_q;
        cfg_ready_d   = cfg_ready_q;
        load_mode_d   = load_mode_q;
        neuron_hold_d = neuron_hold_q;
        cfg_done_d    = cfg_done_q;
        cfg_err_d     = cfg_err_q;
        err_code_d    = err_code_q;
        load_count_d  = load_count_q;
        ser_load      = 1'b0;
        ser_shift     = 1'b0;
        ser_clr       = 1'b0;

        // With enable low everything above simply holds, pulses included.
        if (enable_i) begin
            cfg_done_d = 1'b0;
            cfg_err_d  = 1'b0;

            if (state_q != IDLE && cfg_abort_i) begin
                state_d       = IDLE;
                ser_clr       = 1'b1;
                cfg_ready_d   = 1'b1;
                load_mode_d   = 1'b0;
                neuron_hold_d = 1'b0;
                cfg_err_d     = 1'b1;
                err_code_d    = ERR_ABORT;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (cfg_valid_i && cfg_ready_q) begin
                            if (cfg_tmin_i > cfg_tmax_i) begin
                                cfg_err_d  = 1'b1;
                                err_code_d = ERR_RANGE;
                            end else begin
                                ser_load      = 1'b1;
                                err_code_d    = ERR_OK;
                                state_d       = SHIFT;
                                cfg_ready_d   = 1'b0;
                                load_mode_d   = 1'b1;
                                neuron_hold_d = 1'b1;
                            end
                        end
                    end
                    SHIFT: begin
                        ser_shift = 1'b1;
                        if (!params_ready_i) seen_low_d = 1'b1;
                        if (ser_last) begin
                            state_d     = WAIT;
                            load_mode_d = 1'b0;
                            timer_d     = '0;
                            seen_low_d  = 1'b0;
                        end
                    end
                    WAIT: begin
                        if (seen_low_q && params_ready_i) begin
                            state_d       = IDLE;
                            cfg_ready_d   = 1'b1;
                            neuron_hold_d = 1'b0;
                            cfg_done_d    = 1'b1;
                            if (load_count_q != 8'hFF)
                                load_count_d = load_count_q + 8'd1;
                        end else begin
                            if (!params_ready_i) seen_low_d = 1'b1;
                            timer_d = timer_q + 8'd1;
                            if (timer_d == 8'(TIMEOUT_CYC)) begin
                                state_d       = IDLE;
                                cfg_ready_d   = 1'b1;
                                neuron_hold_d = 1'b0;
                                cfg_err_d     = 1'b1;
                                err_code_d    = ERR_TIMEOUT;
                            end
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= IDLE;
            timer_q       <= '0;
            seen_low_q    <= 1'b0;
            cfg_ready_q   <= 1'b1;
            load_mode_q   <= 1'b0;
            neuron_hold_q <= 1'b0;
            cfg_done_q    <= 1'b0;
            cfg_err_q     <= 1'b0;
            err_code_q    <= ERR_OK;
            load_count_q  <= '0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            seen_low_q    <= seen_low_d;
            cfg_ready_q   <= cfg_ready_d;
            load_mode_q   <= load_mode_d;
            neuron_hold_q <= neuron_hold_d;
            cfg_done_q    <= cfg_done_d;
            cfg_err_q     <= cfg_err_d;
            err_code_q    <= err_code_d;
            load_count_q  <= load_count_d;
        end
    end

    assign cfg_ready_o   = cfg_ready_q;
    assign load_mode_o   = load_mode_q;
    assign serial_data_o = ser_msb;
    assign neuron_hold_o = neuron_hold_q;
    assign cfg_done_o    = cfg_done_q;
    assign cfg_err_o     = cfg_err_q;
    assign err_code_o    = err_code_q;
    assign load_count_o  = load_count_q;

endmodule

// File: tb/tb_lif_config_sequencer.sv
// Directed bench for lif_config_sequencer with TIMEOUT_CYC = 8; inputs change
// and outputs are sampled 1 time unit after each rising edge.
module tb_lif_config_sequencer;

    localparam int TO = 8;
    localparam logic [23:0] FRAME_NOM = 24'hA92080;  // 101_010_01_20_80
    localparam logic [23:0] FRAME_EQ  = 24'hE25555;  // 111_000_10_55_55

    logic       clk_i = 1'b0;
    logic       reset_i = 1'b1;
    logic       enable_i = 1'b1;
    logic       cfg_valid_i = 1'b0;
    logic       cfg_ready_o;
    logic [2:0] cfg_weight_a_i = '0;
    logic [2:0] cfg_weight_b_i = '0;
    logic [1:0] cfg_leak_i = '0;
    logic [7:0] cfg_tmin_i = '0;
    logic [7:0] cfg_tmax_i = '0;
    logic       cfg_abort_i = 1'b0;
    logic       params_ready_i = 1'b1;
    logic       load_mode_o, serial_data_o, neuron_hold_o, cfg_done_o, cfg_err_o;
    logic [1:0] err_code_o;
    logic [7:0] load_count_o;

    int n_checks = 0;
    int n_fail = 0;
    int exp_count = 0;

    always #5 clk_i = ~clk_i;

    lif_config_sequencer #(.TIMEOUT_CYC(TO)) dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .enable_i       (enable_i),
        .cfg_valid_i    (cfg_valid_i),
        .cfg_ready_o    (cfg_ready_o),
        .cfg_weight_a_i (cfg_weight_a_i),
        .cfg_weight_b_i (cfg_weight_b_i),
        .cfg_leak_i     (cfg_leak_i),
        .cfg_tmin_i     (cfg_tmin_i),
        .cfg_tmax_i     (cfg_tmax_i),
        .cfg_abort_i    (cfg_abort_i),
        .params_ready_i (params_ready_i),
        .load_mode_o    (load_mode_o),
        .serial_data_o  (serial_data_o),
        .neuron_hold_o  (neuron_hold_o),
        .cfg_done_o     (cfg_done_o),
        .cfg_err_o      (cfg_err_o),
        .err_code_o     (err_code_o),
        .load_count_o   (load_count_o)
    );

    // {ready, load_mode, serial, hold, done, err, err_code[1:0], load_count[7:0]}
    function automatic logic [15:0] outs();
        return {cfg_ready_o, load_mode_o, serial_data_o, neuron_hold_o,
                cfg_done_o, cfg_err_o, err_code_o, load_count_o};
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send_bundle(input logic [2:0] wa, input logic [2:0] wb,
                               input logic [1:0] lk, input logic [7:0] tmin,
                               input logic [7:0] tmax);
        cfg_weight_a_i = wa;
        cfg_weight_b_i = wb;
        cfg_leak_i     = lk;
        cfg_tmin_i     = tmin;
        cfg_tmax_i     = tmax;
        cfg_valid_i    = 1'b1;
        tick();
        cfg_valid_i    = 1'b0;
    endtask

    // Collects serial_data over every enabled load_mode cycle; optional
    // 3-cycle enable gaps are inserted while bit gap1 / gap2 is presented.
    task automatic capture_frame(input int gap1, input int gap2,
                                 output logic [23:0] bits, output int nbits);
        bit g1_done = 1'b0;
        bit g2_done = 1'b0;
        bits  = '0;
        nbits = 0;
        for (int cyc = 0; cyc < 200 && load_mode_o === 1'b1; cyc++) begin
            if ((nbits == gap1 && !g1_done) || (nbits == gap2 && !g2_done)) begin
                if (nbits == gap1) g1_done = 1'b1;
                else               g2_done = 1'b1;
                enable_i = 1'b0;
                repeat (3) tick();
                enable_i = 1'b1;
            end
            bits  = {bits[22:0], serial_data_o};
            nbits = nbits + 1;
            tick();
        end
    endtask

    task automatic confirm_success(input string tag);
        params_ready_i = 1'b0;
        tick();
        params_ready_i = 1'b1;
        tick();
        exp_count = (exp_count < 255) ? exp_count + 1 : 255;
        n_checks++;
        if ({cfg_done_o, cfg_err_o, cfg_ready_o, neuron_hold_o} !== 4'b1010) begin
            n_fail++;
            $display("FAIL %s_done_flags: got done/err/ready/hold=%b expected 1010", tag,
                     {cfg_done_o, cfg_err_o, cfg_ready_o, neuron_hold_o});
        end
        n_checks++;
        if (load_count_o !== 8'(exp_count) || err_code_o !== 2'd0) begin
            n_fail++;
            $display("FAIL %s_count: got count=%0d code=%0d expected count=%0d code=0",
                     tag, load_count_o, err_code_o, exp_count);
        end
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        repeat (2) tick();
        reset_i = 1'b0;
        n_checks++;
        if (outs() !== 16'h8000) begin
            n_fail++;
            $display("FAIL reset_values: got %h expected 8000", outs());
        end
    endtask

    task automatic test_nominal();
        logic [23:0] bits;
        int          nbits;
        send_bundle(3'd5, 3'd2, 2'd1, 8'h20, 8'h80);
        n_checks++;
        if ({load_mode_o, serial_data_o, neuron_hold_o, cfg_ready_o} !== 4'b1110) begin
            n_fail++;
            $display("FAIL nominal_first_bit: got lm/sd/hold/ready=%b expected 1110",
                     {load_mode_o, serial_data_o, neuron_hold_o, cfg_ready_o});
        end
        capture_frame(-1, -1, bits, nbits);
        n_checks++;
        if (bits !== FRAME_NOM || nbits != 24) begin
            n_fail++;
            $display("FAIL nominal_frame: got %h over %0d cycles expected %h over 24",
                     bits, nbits, FRAME_NOM);
        end
        n_checks++;
        if ({load_mode_o, serial_data_o, neuron_hold_o, cfg_ready_o} !== 4'b0010) begin
            n_fail++;
            $display("FAIL nominal_wait_entry: got lm/sd/hold/ready=%b expected 0010",
                     {load_mode_o, serial_data_o, neuron_hold_o, cfg_ready_o});
        end
        confirm_success("nominal");
        tick();
        n_checks++;
        if (cfg_done_o !== 1'b0) begin
            n_fail++;
            $display("FAIL nominal_done_pulse: got %b expected 0", cfg_done_o);
        end
    endtask

    task automatic test_range();
        send_bundle(3'd1, 3'd1, 2'd0, 8'h90, 8'h10);
        n_checks++;
        if ({cfg_err_o, err_code_o, cfg_ready_o, load_mode_o, neuron_hold_o} !== 6'b101100) begin
            n_fail++;
            $display("FAIL range_reject: got err/code/ready/lm/hold=%b expected 101100",
                     {cfg_err_o, err_code_o, cfg_ready_o, load_mode_o, neuron_hold_o});
        end
        tick();
        n_checks++;
        if ({cfg_err_o, cfg_ready_o, load_mode_o, err_code_o} !== 5'b01001) begin
            n_fail++;
            $display("FAIL range_after: got err/ready/lm/code=%b expected 01001",
                     {cfg_err_o, cfg_ready_o, load_mode_o, err_code_o});
        end
    endtask

    task automatic run_timeout(input string tag, input logic pr_level);
        send_bundle(3'd3, 3'd4, 2'd2, 8'h01, 8'hFE);
        n_checks++;
        if (err_code_o !== 2'd0) begin
            n_fail++;
            $display("FAIL %s_code_cleared: got %0d expected 0", tag, err_code_o);
        end
        repeat (24) tick();
        params_ready_i = pr_level;
        repeat (TO - 1) tick();
        n_checks++;
        if (cfg_err_o !== 1'b0 || neuron_hold_o !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_early: got err=%b hold=%b expected err=0 hold=1",
                     tag, cfg_err_o, neuron_hold_o);
        end
        tick();
        n_checks++;
        if ({cfg_err_o, err_code_o, cfg_ready_o, neuron_hold_o, cfg_done_o} !== 6'b110100) begin
            n_fail++;
            $display("FAIL %s_fire: got err/code/ready/hold/done=%b expected 110100",
                     tag, {cfg_err_o, err_code_o, cfg_ready_o, neuron_hold_o, cfg_done_o});
        end
        params_ready_i = 1'b1;
        tick();
    endtask

    task automatic test_timeout();
        run_timeout("timeout_low", 1'b0);
        run_timeout("timeout_stale_high", 1'b1);
    endtask

    task automatic test_abort();
        send_bundle(3'd5, 3'd2, 2'd1, 8'h20, 8'h80);
        repeat (10) tick();
        cfg_abort_i = 1'b1;
        tick();
        cfg_abort_i = 1'b0;
        n_checks++;
        if ({load_mode_o, serial_data_o, neuron_hold_o, cfg_ready_o, cfg_err_o, err_code_o}
            !== 7'b0001111 || load_count_o !== 8'(exp_count)) begin
            n_fail++;
            $display("FAIL abort_shift: got lm/sd/hold/ready/err/code=%b count=%0d expected 0001111 count=%0d",
                     {load_mode_o, serial_data_o, neuron_hold_o, cfg_ready_o, cfg_err_o, err_code_o},
                     load_count_o, exp_count);
        end
        send_bundle(3'd5, 3'd2, 2'd1, 8'h20, 8'h80);
        repeat (24) tick();
        params_ready_i = 1'b0;
        tick();
        params_ready_i = 1'b1;
        cfg_abort_i    = 1'b1;
        tick();
        cfg_abort_i    = 1'b0;
        n_checks++;
        if ({cfg_done_o, cfg_err_o, err_code_o} !== 4'b0111 || load_count_o !== 8'(exp_count)) begin
            n_fail++;
            $display("FAIL abort_vs_success: got done/err/code=%b count=%0d expected 0111 count=%0d",
                     {cfg_done_o, cfg_err_o, err_code_o}, load_count_o, exp_count);
        end
        cfg_abort_i = 1'b1;
        tick();
        cfg_abort_i = 1'b0;
        n_checks++;
        if ({cfg_err_o, err_code_o, cfg_ready_o, cfg_done_o} !== 5'b01110) begin
            n_fail++;
            $display("FAIL abort_idle_ignored: got err/code/ready/done=%b expected 01110",
                     {cfg_err_o, err_code_o, cfg_ready_o, cfg_done_o});
        end
    endtask

    task automatic test_enable_gaps();
        logic [23:0] bits;
        int          nbits;
        send_bundle(3'd5, 3'd2, 2'd1, 8'h20, 8'h80);
        capture_frame(5, 20, bits, nbits);
        n_checks++;
        if (bits !== FRAME_NOM || nbits != 24) begin
            n_fail++;
            $display("FAIL gaps_frame: got %h over %0d enabled cycles expected %h over 24",
                     bits, nbits, FRAME_NOM);
        end
        confirm_success("gaps");
    endtask

    task automatic test_back_to_back();
        logic [23:0] bits;
        int          nbits;
        send_bundle(3'd7, 3'd0, 2'd2, 8'h55, 8'h55);
        capture_frame(-1, -1, bits, nbits);
        n_checks++;
        if (bits !== FRAME_EQ || nbits != 24) begin
            n_fail++;
            $display("FAIL b2b_equal_window_frame: got %h over %0d expected %h over 24",
                     bits, nbits, FRAME_EQ);
        end
        confirm_success("b2b_first");
        send_bundle(3'd5, 3'd2, 2'd1, 8'h20, 8'h80);
        n_checks++;
        if ({load_mode_o, serial_data_o, cfg_ready_o, cfg_done_o} !== 4'b1100) begin
            n_fail++;
            $display("FAIL b2b_accept: got lm/sd/ready/done=%b expected 1100",
                     {load_mode_o, serial_data_o, cfg_ready_o, cfg_done_o});
        end
        capture_frame(-1, -1, bits, nbits);
        n_checks++;
        if (bits !== FRAME_NOM || nbits != 24) begin
            n_fail++;
            $display("FAIL b2b_second_frame: got %h over %0d expected %h over 24",
                     bits, nbits, FRAME_NOM);
        end
        confirm_success("b2b_second");
    endtask

    task automatic test_reset_mid_shift();
        send_bundle(3'd5, 3'd2, 2'd1, 8'h20, 8'h80);
        repeat (6) tick();
        reset_i = 1'b1;
        tick();
        n_checks++;
        if (outs() !== 16'h8000) begin
            n_fail++;
            $display("FAIL reset_mid_shift: got %h expected 8000", outs());
        end
        reset_i = 1'b0;
        exp_count = 0;
        repeat (3) tick();
        n_checks++;
        if (outs() !== 16'h8000) begin
            n_fail++;
            $display("FAIL reset_no_resume: got %h expected 8000", outs());
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 256; i++) begin
            send_bundle(3'd1, 3'd2, 2'd3, 8'h00, 8'hFF);
            repeat (24) tick();
            params_ready_i = 1'b0;
            tick();
            params_ready_i = 1'b1;
            tick();
            if (i == 254) begin
                n_checks++;
                if (load_count_o !== 8'd255 || cfg_done_o !== 1'b1) begin
                    n_fail++;
                    $display("FAIL sat_255: got count=%0d done=%b expected 255 done=1",
                             load_count_o, cfg_done_o);
                end
            end
        end
        n_checks++;
        if (load_count_o !== 8'd255 || cfg_done_o !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_hold: got count=%0d done=%b expected 255 done=1",
                     load_count_o, cfg_done_o);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_range();
        test_timeout();
        test_abort();
        test_enable_gaps();
        test_back_to_back();
        test_reset_mid_shift();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time budget exhausted before summary");
        $fatal(1, "watchdog expired");
    end

endmodule
